// File: rtl/xmem_bus_arbiter.sv
// Two-requester round-robin arbiter in front of one Versat memory databus port.
// One transaction in flight at a time; a watchdog aborts accesses the memory never acknowledges.
module xmem_bus_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  eng_busy,
  input  logic                  m0_valid,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic                  m0_ready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_valid,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic                  m1_ready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_err,
  output logic                  t_valid,
  output logic [ADDR_W-1:0]     t_addr,
  output logic [DATA_W-1:0]     t_wdata,
  output logic [DATA_W/8-1:0]   t_wstrb,
  input  logic                  t_ready,
  input  logic [DATA_W-1:0]     t_rdata,
  output logic [1:0]            grant,
  output logic [1:0]            dbgState
);

  // Handshake: a requester holds mN_valid and its payload stable until it sees the
  // one-cycle mN_ready pulse, and stays idle for the cycle after it. Towards memory,
  // t_valid and t_* stay stable until t_ready is sampled high; t_rdata is taken that edge.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = TIMEOUT_W'(1);

  logic [1:0]           state;
  logic                 lastGrant;  // 1: m1 owned the previous transaction
  logic [TIMEOUT_W-1:0] wdCount;
  logic                 pickM1;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pickM1 = m1_valid & (~m0_valid | ~lastGrant);
  end

  assign dbgState = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      wdCount   <= '0;
      t_valid   <= 1'b0;
      t_addr    <= '0;
      t_wdata   <= '0;
      t_wstrb   <= '0;
      grant     <= 2'b00;
      m0_ready  <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_ready  <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The engine's address generators own the memory while a run is active.
          if (!eng_busy && (m0_valid || m1_valid)) begin
            state     <= REQ;
            t_valid   <= 1'b1;
            t_addr    <= pickM1 ? m1_addr  : m0_addr;
            t_wdata   <= pickM1 ? m1_wdata : m0_wdata;
            t_wstrb   <= pickM1 ? m1_wstrb : m0_wstrb;
            grant     <= pickM1 ? 2'b10 : 2'b01;
            lastGrant <= pickM1;
            wdCount   <= '0;
          end
        end
        REQ: begin
          if (t_ready) begin
            state    <= RESP;
            t_valid  <= 1'b0;
            m0_ready <= grant[0];
            m1_ready <= grant[1];
            m0_rdata <= grant[0] ? t_rdata : '0;
            m1_rdata <= grant[1] ? t_rdata : '0;
          end else if (wdCount == WD_LAST) begin
            state    <= RESP;
            t_valid  <= 1'b0;
            m0_ready <= grant[0];
            m1_ready <= grant[1];
            m0_err   <= grant[0];
            m1_err   <= grant[1];
            m0_rdata <= '0;
            m1_rdata <= '0;
          end else begin
            wdCount <= wdCount + WD_ONE;
          end
        end
        RESP: begin
          state    <= IDLE;
          grant    <= 2'b00;
          m0_ready <= 1'b0;
          m0_rdata <= '0;
          m0_err   <= 1'b0;
          m1_ready <= 1'b0;
          m1_rdata <= '0;
          m1_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xmem_bus_arbiter.sv
// Bench for xmem_bus_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized two-requester run against a transaction-level memory reference.
module tb_xmem_bus_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rst;
  logic eng_busy;
  logic m0_valid, m1_valid;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
  logic m0_ready, m1_ready, m0_err, m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic t_valid;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  logic [STRB_W-1:0] t_wstrb;
  logic t_ready;
  logic [DATA_W-1:0] t_rdata;
  logic [1:0] grant, dbgState;

  xmem_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .eng_busy(eng_busy),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .t_valid(t_valid), .t_addr(t_addr), .t_wdata(t_wdata), .t_wstrb(t_wstrb),
    .t_ready(t_ready), .t_rdata(t_rdata), .grant(grant), .dbgState(dbgState)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int badCycles = 0;
  int doneCnt [2];
  logic [DATA_W-1:0] doneOrder[$];
  logic [DATA_W-1:0] exp_q[$];

  logic [DATA_W-1:0] mem    [0:1023];
  logic [DATA_W-1:0] refMem [0:1023];
  int memLat = 5;
  bit memHang = 1'b0;
  bit memRandLat = 1'b0;
  int curLat = 1;
  int memCnt = 0;
  bit rndDone = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    int                lat;
    logic [DATA_W-1:0] expRdata;
  } vec_t;
  vec_t vecs [10];

  function automatic logic [DATA_W-1:0] mergeStrobe(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [STRB_W-1:0] st);
    logic [DATA_W-1:0] r = old;
    for (int b = 0; b < STRB_W; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory target: acknowledges after curLat cycles of t_valid; garbage on t_rdata otherwise.
  always @(negedge clk) begin
    if (t_valid && !memHang) begin
      if (memCnt == 0) curLat = memRandLat ? int'($urandom_range(1, 6)) : memLat;
      memCnt++;
      if (memCnt == curLat) begin
        t_ready = 1'b1;
        if (t_wstrb == '0) t_rdata = mem[t_addr];
        else begin
          t_rdata = '0;
          mem[t_addr] = mergeStrobe(mem[t_addr], t_wdata, t_wstrb);
        end
      end
    end else begin
      memCnt  = 0;
      t_ready = 1'b0;
      t_rdata = $urandom;
    end
  end

  // Always-true properties: grant never both, never two completions at once.
  always @(negedge clk) begin
    if (grant == 2'b11 || (m0_ready && m1_ready)) badCycles++;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setReq(input int n, input logic v, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    if (n == 0) begin m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s; end
    else        begin m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s; end
  endtask

  // Called at a negedge. lat = cycles from the first sampling edge to mN_ready (-1: none).
  task automatic doReq(input int n, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [STRB_W-1:0] s, output int lat, output logic [DATA_W-1:0] rd,
                       output logic err, output int waited);
    int cyc = 0;
    bit got = 1'b0;
    int snap;
    logic [DATA_W-1:0] exp;
    setReq(n, 1'b1, a, d, s);
    snap = doneCnt[1-n];
    while (!got && cyc < 300) begin
      @(posedge clk);
      @(negedge clk);
      if ((n == 0) ? m0_ready : m1_ready) got = 1'b1;
      else cyc++;
    end
    rd  = (n == 0) ? m0_rdata : m1_rdata;
    err = (n == 0) ? m0_err : m1_err;
    lat = got ? cyc : -1;
    waited = doneCnt[1-n] - snap;
    if (got) begin
      doneCnt[n]++;
      doneOrder.push_back(DATA_W'(n));
      exp = (s == '0) ? refMem[a] : '0;
      check("sb_rdata", rd, exp);
      check("sb_grant", {30'd0, grant}, (n == 0) ? 32'd1 : 32'd2);
      if (s != '0) refMem[a] = mergeStrobe(refMem[a], d, s);
    end else begin
      check("req_timeout", 32'd0, 32'd1);
    end
    setReq(n, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rndRun(input int n);
    int lat, waited;
    logic [DATA_W-1:0] rd;
    logic err;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      doReq(n, ADDR_W'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 1) == 1) ? STRB_W'($urandom_range(1, 15)) : '0, lat, rd, err, waited);
      check("rnd_err", {31'd0, err}, 32'd0);
      check("rnd_fair", {31'd0, (waited <= 1)}, 32'd1);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int lat, waited, cnt;
    bit got;
    logic [DATA_W-1:0] rd;
    logic err;

    for (int i = 0; i < 1024; i++) begin mem[i] = '0; refMem[i] = '0; end
    doneCnt[0] = 0; doneCnt[1] = 0;
    vecs[0] = '{10'h005, 32'hDEADBEEF, 4'hF, 5, 32'h0};
    vecs[1] = '{10'h005, 32'h0,        4'h0, 5, 32'hDEADBEEF};
    vecs[2] = '{10'h006, 32'h12345678, 4'h3, 2, 32'h0};
    vecs[3] = '{10'h006, 32'h0,        4'h0, 1, 32'h00005678};
    vecs[4] = '{10'h006, 32'hAABBCCDD, 4'h8, 3, 32'h0};
    vecs[5] = '{10'h006, 32'h0,        4'h0, 3, 32'hAA005678};
    vecs[6] = '{10'h007, 32'h0,        4'h0, 5, 32'h0};
    vecs[7] = '{10'h001, 32'h11111111, 4'hF, 4, 32'h0};
    vecs[8] = '{10'h002, 32'h22222222, 4'hF, 4, 32'h0};
    vecs[9] = '{10'h002, 32'h0,        4'h0, 2, 32'h22222222};

    // ---------------- reset ----------------
    rst = 1'b1; eng_busy = 1'b0;
    setReq(0, 1'b0, '0, '0, '0);
    setReq(1, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_t_valid", {31'd0, t_valid}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    check("rst_t_addr", {22'd0, t_addr}, 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- vector table on m0 ----------------
    for (int i = 0; i < 10; i++) begin
      memLat = vecs[i].lat;
      doReq(0, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat, rd, err, waited);
      check("vec_rdata", rd, vecs[i].expRdata);
      check("vec_err", {31'd0, err}, 32'd0);
      check("vec_latency", lat, vecs[i].lat);
    end
    memLat = 5;

    // ---------------- engine busy holds off a grant ----------------
    eng_busy = 1'b1;
    setReq(1, 1'b1, 10'h002, '0, '0);
    cnt = 0;
    repeat (20) begin @(posedge clk); @(negedge clk); if (t_valid) cnt++; end
    check("busy_no_tvalid", cnt, 0);
    eng_busy = 1'b0;
    @(posedge clk); @(negedge clk);
    check("busy_release_tvalid", {31'd0, t_valid}, 32'd1);
    check("busy_release_addr", {22'd0, t_addr}, 32'h002);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); @(negedge clk);
      if (m1_ready) begin got = 1'b1; rd = m1_rdata; end
    end
    check("busy_done", {31'd0, got}, 32'd1);
    check("busy_rdata", rd, 32'h22222222);
    doneCnt[1]++;
    setReq(1, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);

    // ---------------- simultaneous requesters alternate ----------------
    doneOrder.delete();
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    fork
      begin
        int l0, w0; logic [DATA_W-1:0] r0; logic e0;
        repeat (2) doReq(0, 10'h001, '0, '0, l0, r0, e0, w0);
      end
      begin
        int l1, w1; logic [DATA_W-1:0] r1; logic e1;
        repeat (2) doReq(1, 10'h002, '0, '0, l1, r1, e1, w1);
      end
    join
    check("rr_count", doneOrder.size(), 4);
    while (exp_q.size() > 0 && doneOrder.size() > 0)
      check("rr_order", doneOrder.pop_front(), exp_q.pop_front());

    // ---------------- watchdog abort ----------------
    memHang = 1'b1;
    setReq(0, 1'b1, 10'h00A, '0, '0);
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); @(negedge clk);
      if (t_valid) cnt++; else got = 1'b1;
    end
    check("wd_tvalid_cycles", cnt, 64);
    check("wd_ready", {31'd0, m0_ready}, 32'd1);
    check("wd_err", {31'd0, m0_err}, 32'd1);
    check("wd_rdata", m0_rdata, 32'd0);
    setReq(0, 1'b0, '0, '0, '0);
    memHang = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- eng_busy rising mid-transaction ----------------
    fork
      doReq(0, 10'h005, '0, '0, lat, rd, err, waited);
      begin repeat (2) @(negedge clk); eng_busy = 1'b1; end
    join
    check("busy_mid_rdata", rd, 32'hDEADBEEF);
    check("busy_mid_err", {31'd0, err}, 32'd0);
    eng_busy = 1'b0;

    // ---------------- reset during REQ ----------------
    memLat = 10;
    setReq(0, 1'b1, 10'h001, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_pre_tvalid", {31'd0, t_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", {31'd0, t_valid}, 32'd0);
    check("mid_rst_grant", {30'd0, grant}, 32'd0);
    check("mid_rst_addr", {22'd0, t_addr}, 32'd0);
    setReq(0, 1'b0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin @(negedge clk); if (m0_ready || m1_ready) cnt++; end
    check("mid_rst_no_stray_ready", cnt, 0);
    memLat = 5;
    doReq(0, 10'h001, '0, '0, lat, rd, err, waited);
    check("post_rst_rdata", rd, 32'h11111111);
    check("post_rst_latency", lat, 5);

    // ---------------- randomized two-requester run ----------------
    memRandLat = 1'b1;
    fork
      begin
        fork
          rndRun(0);
          rndRun(1);
        join
        rndDone = 1'b1;
      end
      begin
        while (!rndDone) begin
          @(negedge clk);
          eng_busy = ($urandom_range(0, 7) == 0);
        end
        eng_busy = 1'b0;
      end
    join

    check("no_illegal_cycles", badCycles, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
